// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the two-requester memory bus arbiter:
// state, grant and access-size codes plus the latched request record.
package mem_bus_arbiter_pkg;

  localparam int RegBus = 32;

  localparam logic [1:0] StateIdle = 2'd0;
  localparam logic [1:0] StateAddr = 2'd1;
  localparam logic [1:0] StateData = 2'd2;

  localparam logic [1:0] GrantNone = 2'd0;
  localparam logic [1:0] GrantInst = 2'd1;
  localparam logic [1:0] GrantData = 2'd2;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [RegBus-1:0] addr;
    logic [RegBus-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Fetch, mem-stage and memory-side handshake signals of the arbiter.
// The arbiter takes the master view; pipeline and memory take the slave view.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic              i_req;
  logic [RegBus-1:0] i_addr;
  logic              i_addr_ok;
  logic              i_data_ok;
  logic [RegBus-1:0] i_rdata;

  logic              d_req;
  logic              d_wr;
  logic [1:0]        d_size;
  logic [RegBus-1:0] d_addr;
  logic [RegBus-1:0] d_wdata;
  logic              d_addr_ok;
  logic              d_data_ok;
  logic [RegBus-1:0] d_rdata;

  logic              bus_req;
  logic              bus_wr;
  logic [1:0]        bus_size;
  logic [RegBus-1:0] bus_addr;
  logic [RegBus-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [RegBus-1:0] bus_rdata;

  modport master (
    input  i_req, i_addr,
    output i_addr_ok, i_data_ok, i_rdata,
    input  d_req, d_wr, d_size, d_addr, d_wdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    output i_req, i_addr,
    input  i_addr_ok, i_data_ok, i_rdata,
    output d_req, d_wr, d_size, d_addr, d_wdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter between instruction fetch and the mem stage.
// Data wins ties unless fetch has waited through STARVE_LIMIT data grants.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.master   bus,
  output logic                stallreq_mem
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

  logic [1:0]       state;
  logic [1:0]       grant;
  logic [CNT_W-1:0] cnt;
  bus_req_t         lat;

  logic at_limit;
  logic pick_data;
  logic pick_inst;
  logic in_addr;
  logic in_data;
  logic addr_hit;
  logic done;

  assign at_limit  = (cnt == Limit);
  assign pick_data = bus.d_req && !(bus.i_req && at_limit);
  assign pick_inst = bus.i_req && !pick_data;
  assign in_addr   = (state == StateAddr);
  assign in_data   = (state == StateData);
  assign addr_hit  = in_addr && bus.bus_addr_ok;
  assign done      = (addr_hit && bus.bus_data_ok) || (in_data && bus.bus_data_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= StateIdle;
      grant <= GrantNone;
      cnt   <= '0;
      lat   <= '0;
    end else begin
      case (state)
        StateIdle: begin
          if (pick_data) begin
            grant <= GrantData;
            state <= StateAddr;
            lat   <= '{wr: bus.d_wr, size: bus.d_size, addr: bus.d_addr, wdata: bus.d_wdata};
            // A waiting fetch is what makes a data grant count toward starvation.
            if (bus.i_req) begin
              cnt <= at_limit ? cnt : cnt + 1'b1;
            end else begin
              cnt <= '0;
            end
          end else if (pick_inst) begin
            grant <= GrantInst;
            state <= StateAddr;
            lat   <= '{wr: 1'b0, size: SizeWord, addr: bus.i_addr, wdata: '0};
            cnt   <= '0;
          end
        end
        StateAddr: begin
          if (bus.bus_addr_ok) begin
            if (bus.bus_data_ok) begin
              state <= StateIdle;
              grant <= GrantNone;
            end else begin
              state <= StateData;
            end
          end
        end
        StateData: begin
          if (bus.bus_data_ok) begin
            state <= StateIdle;
            grant <= GrantNone;
          end
        end
        default: begin
          state <= StateIdle;
          grant <= GrantNone;
        end
      endcase
    end
  end

  assign bus.bus_req   = in_addr;
  assign bus.bus_wr    = lat.wr;
  assign bus.bus_size  = lat.size;
  assign bus.bus_addr  = lat.addr;
  assign bus.bus_wdata = lat.wdata;

  assign bus.i_addr_ok = addr_hit && (grant == GrantInst);
  assign bus.d_addr_ok = addr_hit && (grant == GrantData);
  assign bus.i_data_ok = done && (grant == GrantInst);
  assign bus.d_data_ok = done && (grant == GrantData);
  assign bus.i_rdata   = bus.bus_rdata;
  assign bus.d_rdata   = bus.bus_rdata;

  // Held low during reset even if the mem stage keeps its request raised.
  assign stallreq_mem = rst && ((bus.d_req && !bus.d_addr_ok) ||
                                ((grant == GrantData) && (state != StateIdle) && !bus.d_data_ok));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed-vector bench for mem_bus_arbiter: write, tie-break, starvation,
// combined handshake, asynchronous reset mid-transaction and a slow memory.
module tb_mem_bus_arbiter;

  logic clk;
  logic rst;
  logic stallreq_mem;

  int checkCount = 0;
  int failCount  = 0;

  mem_bus_arbiter_if bus_if ();

  mem_bus_arbiter #(
    .STARVE_LIMIT (4),
    .CNT_W        (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if.master),
    .stallreq_mem (stallreq_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives the handshake inputs on the falling edge; outputs are sampled 1 unit later.
  task automatic applyStimulus(input logic ireq, input logic dreq, input logic aok, input logic dok);
    @(negedge clk);
    bus_if.i_req       = ireq;
    bus_if.d_req       = dreq;
    bus_if.bus_addr_ok = aok;
    bus_if.bus_data_ok = dok;
    #1;
  endtask

  logic expData [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic found;

  initial begin
    rst = 1'b1;
    bus_if.i_req = 0; bus_if.i_addr = '0;
    bus_if.d_req = 0; bus_if.d_wr = 0; bus_if.d_size = '0; bus_if.d_addr = '0; bus_if.d_wdata = '0;
    bus_if.bus_addr_ok = 0; bus_if.bus_data_ok = 0; bus_if.bus_rdata = '0;
    #1 rst = 1'b0;

    applyStimulus(0, 0, 0, 0);
    checkOutput("rst_bus_req", bus_if.bus_req, 0);
    checkOutput("rst_stall", stallreq_mem, 0);
    checkOutput("rst_bus_addr", bus_if.bus_addr, 0);
    checkOutput("rst_d_addr_ok", bus_if.d_addr_ok, 0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] single data write");
    bus_if.d_wr = 1; bus_if.d_size = 2'd2; bus_if.d_addr = 32'h8000_0010; bus_if.d_wdata = 32'hDEAD_BEEF;
    applyStimulus(0, 1, 0, 0);
    checkOutput("w_idle_bus_req", bus_if.bus_req, 0);
    checkOutput("w_idle_stall", stallreq_mem, 1);
    applyStimulus(0, 1, 1, 0);
    checkOutput("w_bus_req", bus_if.bus_req, 1);
    checkOutput("w_bus_addr", bus_if.bus_addr, 32'h8000_0010);
    checkOutput("w_bus_wdata", bus_if.bus_wdata, 32'hDEAD_BEEF);
    checkOutput("w_bus_wr", bus_if.bus_wr, 1);
    checkOutput("w_bus_size", bus_if.bus_size, 2);
    checkOutput("w_d_addr_ok", bus_if.d_addr_ok, 1);
    checkOutput("w_d_data_ok_early", bus_if.d_data_ok, 0);
    checkOutput("w_stall_addr", stallreq_mem, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("w_data_bus_req", bus_if.bus_req, 0);
    checkOutput("w_data_addr_ok", bus_if.d_addr_ok, 0);
    checkOutput("w_data_stall", stallreq_mem, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("w_d_data_ok", bus_if.d_data_ok, 1);
    checkOutput("w_stall_done", stallreq_mem, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("w_after_data_ok", bus_if.d_data_ok, 0);
    checkOutput("w_hold_addr", bus_if.bus_addr, 32'h8000_0010);

    $display("[TB] simultaneous requests, combined handshake");
    bus_if.i_addr = 32'hBFC0_0000; bus_if.d_addr = 32'h8000_0020; bus_if.bus_rdata = 32'h1234_5678;
    applyStimulus(1, 1, 1, 1);
    checkOutput("s_idle_i_addr_ok", bus_if.i_addr_ok, 0);
    applyStimulus(1, 1, 1, 1);
    checkOutput("s_d_addr_ok", bus_if.d_addr_ok, 1);
    checkOutput("s_d_data_ok", bus_if.d_data_ok, 1);
    checkOutput("s_i_addr_ok", bus_if.i_addr_ok, 0);
    checkOutput("s_d_rdata", bus_if.d_rdata, 32'h1234_5678);
    checkOutput("s_bus_addr_d", bus_if.bus_addr, 32'h8000_0020);
    applyStimulus(1, 0, 1, 1);
    checkOutput("s_idle_bus_req", bus_if.bus_req, 0);
    checkOutput("s_idle_i_ok", bus_if.i_addr_ok, 0);
    bus_if.bus_rdata = 32'h2402_0001;
    applyStimulus(1, 0, 1, 1);
    checkOutput("s_i_addr_ok2", bus_if.i_addr_ok, 1);
    checkOutput("s_i_data_ok", bus_if.i_data_ok, 1);
    checkOutput("s_i_rdata", bus_if.i_rdata, 32'h2402_0001);
    checkOutput("s_bus_addr_i", bus_if.bus_addr, 32'hBFC0_0000);
    checkOutput("s_bus_wr_i", bus_if.bus_wr, 0);
    checkOutput("s_bus_size_i", bus_if.bus_size, 2);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] starvation");
    for (int k = 0; k < 6; k++) begin
      found = 1'b0;
      for (int c = 0; c < 4 && !found; c++) begin
        applyStimulus(1, 1, 1, 1);
        if (bus_if.i_addr_ok || bus_if.d_addr_ok) found = 1'b1;
      end
      checkOutput($sformatf("starve_seen_%0d", k), found, 1);
      checkOutput($sformatf("starve_d_%0d", k), bus_if.d_addr_ok, expData[k]);
      checkOutput($sformatf("starve_i_%0d", k), bus_if.i_addr_ok, !expData[k]);
    end

    $display("[TB] reset mid-transaction");
    bus_if.d_wr = 0; bus_if.d_addr = 32'h8000_0100;
    applyStimulus(0, 1, 0, 0);
    checkOutput("r_idle_bus_req", bus_if.bus_req, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("r_d_addr_ok", bus_if.d_addr_ok, 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("r_data_stall", stallreq_mem, 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("r_async_stall", stallreq_mem, 0);
    checkOutput("r_async_bus_addr", bus_if.bus_addr, 0);
    checkOutput("r_async_bus_req", bus_if.bus_req, 0);
    bus_if.bus_data_ok = 1;
    #1;
    checkOutput("r_async_data_ok", bus_if.d_data_ok, 0);
    @(negedge clk);
    rst = 1'b1;
    bus_if.bus_data_ok = 0;
    #1;
    checkOutput("r_release_bus_req", bus_if.bus_req, 0);

    $display("[TB] slow memory");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus_if.i_addr = 32'hBFC0_0040;
      applyStimulus(i >= 2, 1, 0, 0);
      checkOutput($sformatf("slow_bus_req_%0d", i), bus_if.bus_req, 1);
      checkOutput($sformatf("slow_bus_addr_%0d", i), bus_if.bus_addr, 32'h8000_0100);
      checkOutput($sformatf("slow_d_addr_ok_%0d", i), bus_if.d_addr_ok, 0);
      checkOutput($sformatf("slow_i_addr_ok_%0d", i), bus_if.i_addr_ok, 0);
      checkOutput($sformatf("slow_stall_%0d", i), stallreq_mem, 1);
    end
    applyStimulus(1, 1, 1, 0);
    checkOutput("slow_d_addr_ok", bus_if.d_addr_ok, 1);
    checkOutput("slow_i_addr_ok", bus_if.i_addr_ok, 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("slow_d_data_ok", bus_if.d_data_ok, 1);
    checkOutput("slow_stall_done", stallreq_mem, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("slow_idle_i_ok", bus_if.i_addr_ok, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("slow_fetch_req", bus_if.bus_req, 1);
    checkOutput("slow_fetch_addr", bus_if.bus_addr, 32'hBFC0_0040);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
